// File: rtl/onchip_memory_read_master_pkg.sv
// rtl/onchip_memory_read_master_pkg.sv - shared types and constants for the on-chip memory read master
package onchip_memory_read_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 32 / 8;

    // Byte-address step between consecutive words for a given data width
    function automatic int addr_inc(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_read_fifo.sv
// rtl/onchip_read_fifo.sv - synchronous word FIFO buffering read responses toward the stream port
module onchip_read_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when a pop frees the slot on the same edge
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));

endmodule

// File: rtl/onchip_memory_read_master.sv
// rtl/onchip_memory_read_master.sv - credit-limited Avalon-MM pipelined block read master with stream output
module onchip_memory_read_master
    import onchip_memory_read_master_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_address,
    input  logic [LEN_W-1:0]    word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready
);

    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_INC = addr_inc(DATA_W);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [CW-1:0]      pending_q, pending_d;
    logic               done_q, done_d;

    logic               fifo_empty, fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [DATA_W-1:0]  fifo_rdata;
    logic               req_accept, rsp_accept, pop;
    logic [CW:0]        credits_used;

    // Outstanding requests plus buffered words never exceed the FIFO depth
    assign credits_used   = {1'b0, pending_q} + {1'b0, fifo_count};
    assign avm_read       = (state_q == ST_READ) && (remaining_q != '0) &&
                            (credits_used < (CW+1)'(FIFO_DEPTH));
    assign avm_address    = addr_q;
    assign avm_byteenable = '1;
    assign req_accept     = avm_read & ~avm_waitrequest;

    // Responses outside an active transfer are stale and dropped
    assign rsp_accept = avm_readdatavalid && (pending_q != '0) &&
                        ((state_q == ST_READ) || (state_q == ST_DRAIN));

    assign st_valid = ~fifo_empty;
    assign st_data  = fifo_empty ? '0 : fifo_rdata;
    assign pop      = st_valid & st_ready;

    assign busy = (state_q != ST_IDLE) | done_q;
    assign done = done_q;

    // Transfer sequencing, address/count bookkeeping and outstanding-request tracking
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = (state_q == ST_FINISH);
        pending_d   = pending_q + CW'(req_accept) - CW'(rsp_accept);
        unique case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    addr_d      = base_address & ~ADDR_W'(3);
                    remaining_d = word_count;
                    state_d     = (word_count != '0) ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                if (req_accept) begin
                    addr_d      = addr_q + ADDR_W'(ADDR_INC);
                    remaining_d = remaining_q - LEN_W'(1);
                end
                if (remaining_d == '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pending_q == '0 && fifo_empty) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pending_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    onchip_read_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_accept),
        .pop     (pop),
        .wdata   (avm_readdata),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
